// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, timing
// count helpers and the bit-index markers used while shifting a frame.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        RELEASE
    } ps2_tx_state_e;

    localparam int IDX_W = 4;

    // Index values reached after the eight data bits have been shifted.
    localparam logic [IDX_W-1:0] PARITY_IDX = 4'd8;
    localparam logic [IDX_W-1:0] STOP_IDX   = 4'd9;

    // Clock cycles the host holds the bus clock low before the start bit.
    function automatic int inhibit_cycles(input int clk_khz, input int inhibit_us);
        return (clk_khz * inhibit_us) / 1000;
    endfunction

    // Clock cycles allowed for the whole transfer after the clock is released.
    function automatic int timeout_cycles(input int clk_khz, input int timeout_ms);
        return clk_khz * timeout_ms;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Brings one asynchronous PS/2 line into the clk domain and deglitches it:
// two synchronizer flops, then the filtered level only moves once four
// consecutive synchronized samples agree.
module ps2_line_filter (
    input  logic clk,
    input  logic reset_n,
    input  logic line_in,
    output logic level
);

    logic [1:0] sync_q, sync_d;
    logic [3:0] samp_q, samp_d;
    logic       level_q, level_d;

    // Shift the synchronizer and sample history; update level on agreement.
    always_comb begin
        sync_d  = {sync_q[0], line_in};
        samp_d  = {samp_q[2:0], sync_q[1]};
        level_d = level_q;
        if (&samp_q) begin
            level_d = 1'b1;
        end else if (~|samp_q) begin
            level_d = 1'b0;
        end
    end

    // Idle bus is high, so everything resets to ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            samp_q  <= 4'b1111;
            level_q <= 1'b1;
        end else begin
            sync_q  <= sync_d;
            samp_q  <= samp_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues the start bit,
// shifts data/parity/stop on device clock falls, checks the acknowledge and
// reports done or err, with an overall transfer timeout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | lines released, ready to accept a byte
//   INHIBIT | holding clock low for the inhibit period
//   START   | releasing clock while data holds the start bit
//   SHIFT   | driving data, parity and stop on device clock falls
//   ACK     | waiting for the fall that carries the device acknowledge
//   RELEASE | waiting for clock high before reporting the result
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_KHZ    = 50000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int INH_RAW = inhibit_cycles(CLK_KHZ, INHIBIT_US);
    localparam int INH_CYC = (INH_RAW < 1) ? 1 : INH_RAW;
    localparam int INH_W   = (INH_CYC < 2) ? 1 : $clog2(INH_CYC);
    localparam int TO_CYC  = timeout_cycles(CLK_KHZ, TIMEOUT_MS);
    localparam int TO_W    = (TO_CYC < 1) ? 1 : $clog2(TO_CYC + 1);

    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INH_CYC - 1);
    localparam logic [TO_W-1:0]  TO_TC    = TO_W'(TO_CYC);

    ps2_tx_state_e    state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic             ack_q, ack_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             clk_prev_q, clk_prev_d;

    logic clk_lvl;
    logic dat_lvl;
    logic clk_fall;
    logic timeout;
    logic done_c;
    logic err_c;

    ps2_line_filter u_clk_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .line_in (ps2_clk_in),
        .level   (clk_lvl)
    );

    ps2_line_filter u_dat_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .line_in (ps2_dat_in),
        .level   (dat_lvl)
    );

    assign clk_prev_d = clk_lvl;
    assign clk_fall   = clk_prev_q & ~clk_lvl;

    // Next-state, datapath and result pulses; timeout overrides everything.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        parity_d  = parity_q;
        ack_d     = ack_q;
        idx_d     = idx_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = '0;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        done_c    = 1'b0;
        err_c     = 1'b0;
        timeout   = 1'b0;

        // Counter sits at zero until START, so START itself is count 0.
        if (state_q inside {START, SHIFT, ACK, RELEASE}) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            timeout  = (to_cnt_q == TO_TC);
        end

        if (timeout) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            err_c    = 1'b1;
            to_cnt_d = '0;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    if (tx_valid) begin
                        data_d    = tx_data;
                        parity_d  = ~^tx_data;
                        inh_cnt_d = INH_LOAD;
                        clk_oe_d  = 1'b1;
                        state_d   = INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt_q == '0) begin
                        dat_oe_d = 1'b1;
                        state_d  = START;
                    end else begin
                        inh_cnt_d = inh_cnt_q - INH_W'(1);
                    end
                end
                START: begin
                    clk_oe_d = 1'b0;
                    idx_d    = '0;
                    state_d  = SHIFT;
                end
                SHIFT: begin
                    if (clk_fall) begin
                        if (idx_q == STOP_IDX) begin
                            dat_oe_d = 1'b0;
                            state_d  = ACK;
                        end else if (idx_q == PARITY_IDX) begin
                            dat_oe_d = ~parity_q;
                        end else begin
                            dat_oe_d = ~data_q[idx_q[2:0]];
                        end
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        ack_d   = ~dat_lvl;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (clk_lvl) begin
                        done_c  = ack_q;
                        err_c   = ~ack_q;
                        state_d = IDLE;
                    end
                end
                default: begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset releases both lines on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            parity_q   <= 1'b0;
            ack_q      <= 1'b0;
            idx_q      <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            ack_q      <= ack_d;
            idx_q      <= idx_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    assign tx_ready   = (state_q == IDLE);
    assign busy       = ~tx_ready;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    // Gated so a reset landing on the reporting cycle never shows a pulse.
    assign done       = done_c & reset_n;
    assign err        = err_c & reset_n;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a small open-drain PS/2 device model.
module tb_ps2_host_tx;

    localparam int CLK_KHZ    = 100;
    localparam int INHIBIT_US = 100;
    localparam int TIMEOUT_MS = 15;
    localparam int INH_EXP    = 10;    // 100 kHz * 100 us
    localparam int TO_EXP     = 1500;  // 100 kHz * 15 ms

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       busy, done, err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int accept_cnt = 0;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_KHZ    (CLK_KHZ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (err === 1'b1) err_cnt <= err_cnt + 1;
        if (done === 1'b1 && err === 1'b1) both_cnt <= both_cnt + 1;
        if (reset_n && tx_valid && tx_ready) accept_cnt <= accept_cnt + 1;
    end

    // Accept a byte, scramble tx_data, and measure the inhibit period.
    task automatic start_tx(input logic [7:0] d, output int t_start);
        int n;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n !== INH_EXP) begin
            miscompares++;
            $display("FAIL inhibit_len: got %0d cycles, expected %0d", n, INH_EXP);
        end
        vectors++;
        if ({ps2_clk_oe, ps2_dat_oe} !== 2'b11) begin
            miscompares++;
            $display("FAIL start_bit: got clk_oe,dat_oe=%b, expected 11", {ps2_clk_oe, ps2_dat_oe});
        end
        t_start = cyc;
    endtask

    // Device model: clocks nfalls falls, records line bit after falls 1..10,
    // drives the acknowledge level before fall 11.
    task automatic device_xfer(input int nfalls, input logic ack, output logic [9:0] bits);
        int n;
        bits = '0;
        n = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL dev_start_wait: got no clock release in %0d cycles, expected release", n);
        end
        repeat (30) @(negedge clk);
        for (int i = 1; i <= nfalls; i++) begin
            if (i == 11) begin
                dev_dat = ack ? 1'b0 : 1'b1;
                repeat (20) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            if (i <= 10) bits[i-1] = ~ps2_dat_oe;
            dev_clk = 1'b1;
            if (i < 11) repeat (20) @(negedge clk);
        end
        dev_dat = 1'b1;
    endtask

    // Wait for the result pulse; tx_ready must be low on it and high right after.
    task automatic wait_end(output logic got_done, output logic got_err);
        int n;
        got_done = 1'b0;
        got_err  = 1'b0;
        n = 0;
        while (done !== 1'b1 && err !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL end_wait: got no done/err in %0d cycles, expected a pulse", n);
        end else begin
            got_done = done;
            got_err  = err;
            vectors++;
            if (tx_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL ready_on_pulse: got %b, expected 0", tx_ready);
            end
            @(negedge clk);
            vectors++;
            if (tx_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL ready_after_pulse: got %b, expected 1", tx_ready);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ps2_clk_oe, ps2_dat_oe, done, err, busy, tx_ready} !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_outputs: got clk_oe,dat_oe,done,err,busy,ready=%b, expected 000001",
                     {ps2_clk_oe, ps2_dat_oe, done, err, busy, tx_ready});
        end
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, tx_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL idle_outputs: got clk_oe,dat_oe,busy,ready=%b, expected 0001",
                     {ps2_clk_oe, ps2_dat_oe, busy, tx_ready});
        end
    endtask

    task automatic test_send(input logic [7:0] d, input logic [9:0] exp_bits, input logic ack);
        int t;
        int d0, e0;
        logic [9:0] bits;
        logic gd, ge;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d, t);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_in_xfer: got %b, expected 1", busy);
        end
        device_xfer(11, ack, bits);
        vectors++;
        if (bits !== exp_bits) begin
            miscompares++;
            $display("FAIL frame_bits_%h: got %h, expected %h", d, bits, exp_bits);
        end
        wait_end(gd, ge);
        vectors++;
        if ({gd, ge} !== {ack, ~ack}) begin
            miscompares++;
            $display("FAIL result_%h: got done,err=%b, expected %b", d, {gd, ge}, {ack, ~ack});
        end
        repeat (20) @(negedge clk);
        vectors++;
        if ((done_cnt - d0) !== (ack ? 1 : 0) || (err_cnt - e0) !== (ack ? 0 : 1)) begin
            miscompares++;
            $display("FAIL pulse_count_%h: got done %0d err %0d, expected done %0d err %0d",
                     d, done_cnt - d0, err_cnt - e0, ack ? 1 : 0, ack ? 0 : 1);
        end
    endtask

    task automatic test_timeout();
        int t0, n;
        int d0;
        start_tx(8'h12, t0);
        d0 = done_cnt;
        n = 0;
        while (err !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n >= 2000) begin
            miscompares++;
            $display("FAIL timeout_wait: got no err in %0d cycles, expected err", n);
        end else begin
            if ((cyc - t0) !== TO_EXP) begin
                miscompares++;
                $display("FAIL timeout_len: got %0d cycles, expected %0d", cyc - t0, TO_EXP);
            end
            @(negedge clk);
            vectors++;
            if ({ps2_clk_oe, ps2_dat_oe, tx_ready} !== 3'b001) begin
                miscompares++;
                $display("FAIL timeout_release: got clk_oe,dat_oe,ready=%b, expected 001",
                         {ps2_clk_oe, ps2_dat_oe, tx_ready});
            end
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (done_cnt !== d0) begin
            miscompares++;
            $display("FAIL timeout_no_done: got %0d done pulses, expected 0", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int d0, e0;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hA5, t);
        device_xfer(4, 1'b0, bits);
        vectors++;
        if ({bits[3:0], ps2_dat_oe} !== 5'b01011) begin
            miscompares++;
            $display("FAIL mid_bits: got bits,dat_oe=%b, expected 01011", {bits[3:0], ps2_dat_oe});
        end
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ps2_clk_oe, ps2_dat_oe, done, err, tx_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL mid_reset: got clk_oe,dat_oe,done,err,ready=%b, expected 00001",
                     {ps2_clk_oe, ps2_dat_oe, done, err, tx_ready});
        end
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        vectors++;
        if (done_cnt !== d0 || err_cnt !== e0 || ps2_dat_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_quiet: got done %0d err %0d dat_oe %b, expected 0 0 0",
                     done_cnt - d0, err_cnt - e0, ps2_dat_oe);
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        logic [9:0] bits;
        logic gd, ge;
        a0 = accept_cnt;
        @(negedge clk);
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data  = 8'h55;
        device_xfer(11, 1'b1, bits);
        vectors++;
        if (bits !== 10'h2F4) begin
            miscompares++;
            $display("FAIL b2b_first_bits: got %h, expected 2f4", bits);
        end
        wait_end(gd, ge);
        vectors++;
        if ({gd, ge, accept_cnt - a0} !== {2'b10, 32'd1}) begin
            miscompares++;
            $display("FAIL b2b_first_end: got done,err=%b accepts %0d, expected 10 and 1",
                     {gd, ge}, accept_cnt - a0);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        vectors++;
        if (accept_cnt - a0 !== 2) begin
            miscompares++;
            $display("FAIL b2b_second_accept: got %0d accepts, expected 2", accept_cnt - a0);
        end
        device_xfer(11, 1'b1, bits);
        vectors++;
        if (bits !== 10'h355) begin
            miscompares++;
            $display("FAIL b2b_second_bits: got %h, expected 355", bits);
        end
        wait_end(gd, ge);
        vectors++;
        if ({gd, ge} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_second_end: got done,err=%b, expected 10", {gd, ge});
        end
    endtask

    task automatic test_exclusive();
        vectors++;
        if (both_cnt !== 0) begin
            miscompares++;
            $display("FAIL done_err_overlap: got %0d cycles, expected 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_send(8'hED, 10'h3ED, 1'b1);
        test_send(8'h00, 10'h300, 1'b1);
        test_send(8'h3C, 10'h33C, 1'b0);
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
